// File: rtl/sm_adder_table_writer.sv
// sm_adder_table_writer: builds a sign-magnitude sum table in RAM with one write per clock, then serves registered lookups.
module sm_adder_table_writer #(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  ready,
   output logic                  done,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH:0]   sum,
   output logic                  sum_valid
);
   localparam int AW = 2 * DATA_WIDTH;
   localparam int M = DATA_WIDTH - 1;
   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE, S_READY} state_t;
   state_t state, state_d;
   logic [AW-1:0] cnt;
   logic [DATA_WIDTH-1:0] x, y, mag;
   logic [M-1:0] mx, my;
   logic sgn;
   logic [DATA_WIDTH:0] entry;
   logic [DATA_WIDTH:0] mem [2**AW];
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= S_IDLE;
      else state <= state_d;
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE, S_READY: state_d = start ? S_FILL : state;
         S_FILL: state_d = (cnt == '1) ? S_DONE : S_FILL;
         default: state_d = S_READY;
      endcase
   end
   always_comb begin
      busy = state == S_FILL;
      ready = state == S_READY;
      done = state == S_DONE;
   end
   // Counter rests at zero outside FILL so every fill starts from address 0.
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else cnt <= (state == S_FILL) ? cnt + AW'(1) : '0;
   always_comb begin
      x = cnt[AW-1:DATA_WIDTH];
      y = cnt[DATA_WIDTH-1:0];
      mx = x[M-1:0];
      my = y[M-1:0];
      mag = (x[M] == y[M]) ? {1'b0, mx} + {1'b0, my} :
            (mx > my) ? {1'b0, mx - my} : {1'b0, my - mx};
      sgn = (mx > my) ? x[M] : y[M];
      entry = {(|mag) & sgn, mag};
   end
   always_ff @(posedge clk)
      if (state == S_FILL) mem[cnt] <= entry;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sum <= '0;
         sum_valid <= 1'b0;
      end else begin
         sum_valid <= rd_en && ready;
         if (rd_en && ready) sum <= mem[{a, b}];
      end
endmodule

// File: tb/tb_sm_adder_table_writer.sv
// tb_sm_adder_table_writer: directed steps with a lookup scoreboard for the sign-magnitude table writer.
module tb_sm_adder_table_writer;
   logic clk = 1'b0;
   logic reset, start, rd_en, busy, ready, done, sum_valid;
   logic [3:0] a, b;
   logic [4:0] sum;
   int errors = 0;
   int checks = 0;
   logic issued = 1'b0;
   logic [4:0] q[$];
   sm_adder_table_writer #(.DATA_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .ready(ready), .done(done),
      .rd_en(rd_en), .a(a), .b(b), .sum(sum), .sum_valid(sum_valid)
   );
   always #5 clk = ~clk;
   function automatic logic [4:0] model(logic [3:0] x, logic [3:0] y);
      int vx, vy, s;
      vx = x[3] ? -int'(x[2:0]) : int'(x[2:0]);
      vy = y[3] ? -int'(y[2:0]) : int'(y[2:0]);
      s = vx + vy;
      return (s < 0) ? {1'b1, 4'(-s)} : {1'b0, 4'(s)};
   endfunction
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      logic pending;
      logic [4:0] e;
      @(posedge clk);
      pending = issued;
      issued = 1'b0;
      @(negedge clk);
      chk("sum_valid", 32'(sum_valid), 32'(pending));
      if (pending) begin
         e = q.pop_front();
         chk("sum", 32'(sum), 32'(e));
      end
   endtask
   task automatic look(logic [3:0] x, logic [3:0] y, logic [4:0] e);
      a = x;
      b = y;
      rd_en = 1'b1;
      issued = 1'b1;
      q.push_back(e);
      tick();
   endtask
   task automatic fill_wait(string tag);
      int n = 0;
      while (busy === 1'b1 && n < 400) begin
         n++;
         start = (n == 100);
         rd_en = (n >= 50 && n < 60);
         a = 4'h4;
         b = 4'h1;
         tick();
      end
      chk({tag, "_busy_cycles"}, 32'(n), 32'd256);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy_off"}, 32'(busy), 32'd0);
      start = 1'b0;
      rd_en = 1'b0;
      tick();
      chk({tag, "_done_off"}, 32'(done), 32'd0);
      chk({tag, "_ready"}, 32'(ready), 32'd1);
   endtask
   initial begin
      reset = 1'b1;
      start = 1'b0;
      rd_en = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_valid", 32'(sum_valid), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("mid_busy", 32'(busy), 32'd1);
      repeat (10) tick();
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(ready), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ready", 32'(ready), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      fill_wait("fill1");
      look(4'b0100, 4'b0001, 5'b0_0101);
      look(4'b0100, 4'b1001, 5'b0_0011);
      look(4'b1111, 4'b0001, 5'b1_0110);
      look(4'b1001, 4'b1010, 5'b1_0011);
      look(4'b1111, 4'b1110, 5'b1_1101);
      look(4'b0100, 4'b1100, 5'b0_0000);
      look(4'b1000, 4'b0000, 5'b0_0000);
      rd_en = 1'b0;
      tick();
      for (int i = 0; i < 256; i++) look(4'(i >> 4), 4'(i), model(4'(i >> 4), 4'(i)));
      rd_en = 1'b0;
      tick();
      start = 1'b1;
      look(4'b1111, 4'b1110, 5'b1_1101);
      start = 1'b0;
      rd_en = 1'b0;
      chk("refill_ready", 32'(ready), 32'd0);
      chk("refill_busy", 32'(busy), 32'd1);
      fill_wait("fill2");
      for (int i = 0; i < 256; i++) look(4'(i >> 4), 4'(i), model(4'(i >> 4), 4'(i)));
      rd_en = 1'b0;
      tick();
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
